// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: FSM states, opcodes and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StHalt
  } state_e;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RA_MSB     = 26;
  localparam int unsigned RA_LSB     = 23;
  localparam int unsigned RB_MSB     = 22;
  localparam int unsigned RB_LSB     = 19;
  localparam int unsigned RC_MSB     = 18;
  localparam int unsigned RC_LSB     = 15;

  function automatic logic is_alu_op(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Decodes a 4-bit register number plus enable into a one-hot register select vector.
module reg_select_decoder #(
  parameter int unsigned NREG = 16
) (
  input  logic [3:0]      i_sel,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      o_onehot[i] = i_en && (i_sel == 4'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the DataPath strobes.
// Optional illegal-opcode trap enabled by defining CTRL_ILLEGAL_TRAP_EN.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREG  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic [4:0]       Operator,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d;

  logic [4:0] w_opcode;
  logic [3:0] w_ra, w_rb, w_rc, w_rout_sel;
  logic       w_is_alu, w_is_nop, w_is_halt;
  logic       w_rin_en, w_rout_en;
  logic       w_unused_ir;

  assign w_opcode    = IR[OPCODE_MSB:OPCODE_LSB];
  assign w_ra        = IR[RA_MSB:RA_LSB];
  assign w_rb        = IR[RB_MSB:RB_LSB];
  assign w_rc        = IR[RC_MSB:RC_LSB];
  assign w_is_alu    = is_alu_op(w_opcode);
  assign w_is_nop    = (w_opcode == OP_NOP);
  assign w_is_halt   = (w_opcode == OP_HALT);
  assign w_unused_ir = ^IR[RC_LSB-1:0];

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal, w_illegal_d;
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (clear) r_illegal <= 1'b0;
    else       r_illegal <= w_illegal_d;
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_illegal_d = r_illegal;
`endif
    unique case (r_state)
      StIdle: if (run) w_state_d = StT0;
      StT0:   w_state_d = StT1;
      StT1:   w_state_d = StT2;
      StT2:   w_state_d = StT3;
      StT3: begin
        if (w_is_alu) begin
          w_state_d = StT4;
        end else if (w_is_halt) begin
          w_state_d = StHalt;
        end else if (w_is_nop) begin
          w_count_d = r_count + CNT_W'(1);
          w_state_d = run ? StT0 : StIdle;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_state_d   = StHalt;
          w_illegal_d = 1'b1;
`else
          // Illegal opcode retires like NOP but is not counted.
          w_state_d = run ? StT0 : StIdle;
`endif
        end
      end
      StT4: w_state_d = StT5;
      StT5: begin
        w_count_d = r_count + CNT_W'(1);
        w_state_d = run ? StT0 : StIdle;
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Operator   = 5'b00000;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_sel = w_rb;
    unique case (r_state)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (w_is_alu) begin
          w_rout_en = 1'b1;
          Yin       = 1'b1;
        end
      end
      StT4: begin
        w_rout_en  = 1'b1;
        w_rout_sel = w_rc;
        Operator   = w_opcode;
        Zin        = 1'b1;
      end
      StT5: begin
        Zlowout  = 1'b1;
        w_rin_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted      = (r_state == StHalt);
  assign instr_count = r_count;

  reg_select_decoder #(
    .NREG(NREG)
  ) u_rin_dec (
    .i_sel    (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  reg_select_decoder #(
    .NREG(NREG)
  ) u_rout_dec (
    .i_sel    (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level reference model, random ALU/NOP mix.
module tb_control_sequencer;

  localparam int unsigned NREG = 16;
  localparam int unsigned CW   = 4;  // narrow counter so the wrap is reachable quickly

  localparam logic [10:0] S_PCOUT   = 11'h400;
  localparam logic [10:0] S_ZLOWOUT = 11'h200;
  localparam logic [10:0] S_MDROUT  = 11'h100;
  localparam logic [10:0] S_MARIN   = 11'h080;
  localparam logic [10:0] S_ZIN     = 11'h040;
  localparam logic [10:0] S_PCIN    = 11'h020;
  localparam logic [10:0] S_MDRIN   = 11'h010;
  localparam logic [10:0] S_IRIN    = 11'h008;
  localparam logic [10:0] S_YIN     = 11'h004;
  localparam logic [10:0] S_INCPC   = 11'h002;
  localparam logic [10:0] S_READ    = 11'h001;

  localparam logic [10:0] E_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [10:0] E_T1 = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [10:0] E_T2 = S_MDROUT | S_IRIN;

  logic            clk = 1'b0;
  logic            clear, run;
  logic [31:0]     IR;
  logic            PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]      Operator;
  logic [NREG-1:0] Rin, Rout;
  logic            halted, illegal;
  logic [CW-1:0]   instr_count;
  logic [10:0]     strb;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] m_count;
  logic          m_halt, m_illegal;

  always #5 clk = ~clk;

  assign strb = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read};

  control_sequencer #(
    .NREG  (NREG),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .run         (run),
    .IR          (IR),
    .PCout       (PCout),
    .Zlowout     (Zlowout),
    .MDRout      (MDRout),
    .MARin       (MARin),
    .Zin         (Zin),
    .PCin        (PCin),
    .MDRin       (MDRin),
    .IRin        (IRin),
    .Yin         (Yin),
    .IncPC       (IncPC),
    .Read        (Read),
    .Operator    (Operator),
    .Rin         (Rin),
    .Rout        (Rout),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'(1) << r;
  endfunction

  // Compare every output against the expectation for the current cycle.
  task automatic cyc(input string tag, input logic [10:0] s, input logic [15:0] ri,
                     input logic [15:0] ro, input logic [4:0] op);
    chk({tag, ".strobes"}, 64'(strb), 64'(s));
    chk({tag, ".Rin"}, 64'(Rin), 64'(ri));
    chk({tag, ".Rout"}, 64'(Rout), 64'(ro));
    chk({tag, ".Operator"}, 64'(Operator), 64'(op));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
    chk({tag, ".illegal"}, 64'(illegal), 64'(m_illegal));
    chk({tag, ".count"}, 64'(instr_count), 64'(m_count));
  endtask

  task automatic do_clear(input int n);
    clear = 1'b1;
    repeat (n) step();
    m_count   = '0;
    m_halt    = 1'b0;
    m_illegal = 1'b0;
    cyc("CLEAR", 11'h0, 16'h0, 16'h0, 5'h0);
    clear = 1'b0;
  endtask

  // Called in a T0 cycle; runs one instruction and leaves the bench in the following cycle.
  task automatic exec(input logic [31:0] ir, input logic keep_run);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       alu;
    op  = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    alu = (op >= 5'd3) && (op <= 5'd10);
    IR  = ir;
    cyc("T0", E_T0, 16'h0, 16'h0, 5'h0);
    run = 1'($urandom);
    step();
    cyc("T1", E_T1, 16'h0, 16'h0, 5'h0);
    run = 1'($urandom);
    step();
    cyc("T2", E_T2, 16'h0, 16'h0, 5'h0);
    run = 1'($urandom);
    step();
    cyc("T3", alu ? S_YIN : 11'h0, 16'h0, alu ? oh(rb) : 16'h0, 5'h0);
    if (alu) begin
      run = 1'($urandom);
      step();
      cyc("T4", S_ZIN, 16'h0, oh(rc), op);
      run = keep_run;
      step();
      cyc("T5", S_ZLOWOUT, oh(ra), 16'h0, 5'h0);
      step();
      m_count = m_count + 1'b1;
    end else if (op == 5'b11011) begin
      step();
      m_halt = 1'b1;
      repeat (3) begin
        cyc("HALT", 11'h0, 16'h0, 16'h0, 5'h0);
        run = 1'($urandom);
        step();
      end
    end else if (op == 5'b00000) begin
      run = keep_run;
      step();
      m_count = m_count + 1'b1;
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      step();
      m_halt    = 1'b1;
      m_illegal = 1'b1;
      repeat (3) begin
        cyc("TRAP", 11'h0, 16'h0, 16'h0, 5'h0);
        run = 1'($urandom);
        step();
      end
`else
      run = keep_run;
      step();
`endif
    end
  endtask

  initial begin
    logic [31:0] rir;
    logic        rkeep;
    clear     = 1'b1;
    run       = 1'b1;
    IR        = 32'h0;
    m_count   = '0;
    m_halt    = 1'b0;
    m_illegal = 1'b0;

    do_clear(2);
    step();  // T0 follows directly once clear drops with run high
    exec(32'h22920000, 1'b0);  // sub R5,R2,R4
    cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);
    chk("sub_count", 64'(instr_count), 64'd1);

    run = 1'b1;
    step();
    exec(32'h1A920000, 1'b1);  // add R5,R2,R4 back-to-back
    exec(32'h1A920000, 1'b0);
    cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);
    chk("b2b_count", 64'(instr_count), 64'd3);

    run = 1'b1;
    step();
    exec(32'hD8000000, 1'b1);  // HALT
    do_clear(1);

    run = 1'b1;
    step();
    exec(32'hF8000000, 1'b0);  // illegal opcode 11111
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_count", 64'(instr_count), 64'd0);
    do_clear(1);
`else
    cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);
    chk("illegal_count", 64'(instr_count), 64'd0);
`endif

    run = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      rir = $urandom;
      if ($urandom_range(0, 8) == 0) rir[31:27] = 5'b00000;
      else rir[31:27] = 5'(3 + $urandom_range(0, 7));
      rkeep = 1'($urandom);
      exec(rir, rkeep);
      if (!rkeep) begin
        cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);
        run = 1'b1;
        step();
      end
    end

    // Abort mid-execute: in T0 now, reach T4 then clear.
    IR = 32'h22920000;
    repeat (4) step();
    chk("abort_T4_op", 64'(Operator), 64'h04);
    do_clear(1);
    run = 1'b0;
    step();
    cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);

    run = 1'b1;
    step();
    repeat ((1 << CW) - 1) exec(32'h0, 1'b1);
    chk("pre_wrap", 64'(instr_count), 64'((1 << CW) - 1));
    exec(32'h0, 1'b0);
    chk("wrap", 64'(instr_count), 64'd0);
    cyc("IDLE", 11'h0, 16'h0, 16'h0, 5'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
